// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit-side sequencer for the UART peripheral. A byte written by the
//   processor is packed into an 11-bit frame: start bit, 7 or 8 data bits,
//   optional parity, and stop bits. The frame is shifted out LSB first on tx.
//   Each bit is held for K clocks. K comes from the baud_sel table, or from
//   BAUD_OVERRIDE when that parameter is nonzero.
//
// Ports
//   clock     system clock (100 MHz)
//   reset     asynchronous, active-low reset
//   load      one-cycle write strobe; accepted only while txrdy=1
//   out_port  byte to transmit
//   baud_sel  rate select, sampled when a load is accepted
//   eight     1 = 8 data bits, 0 = 7 data bits; sampled at load
//   pen       parity enable; sampled at load
//   ohel      1 = odd parity, 0 = even parity; sampled at load
//   tx        serial line; idles high
//   txrdy     1 = engine free to accept a load
//   tx_done   one-cycle pulse when a frame completes
//   busy      1 while a frame is in flight
module uart_tx_engine #(
    parameter int BAUD_OVERRIDE = 0,
    parameter int CNT_W         = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] out_port,
    input  logic [3:0] baud_sel,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    output logic       tx,
    output logic       txrdy,
    output logic       tx_done,
    output logic       busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [10:0]      shreg_q;
    logic [CNT_W-1:0] kmax_q;
    logic [CNT_W-1:0] bit_time_q;
    logic [3:0]       bit_cnt_q;
    logic             tx_done_q;

    logic accept;
    logic btu;
    logic last_bit;

    // Clocks per bit at 100 MHz.
    function automatic logic [CNT_W-1:0] clocks_per_bit(input logic [3:0] sel);
        logic [CNT_W-1:0] k;
        case (sel)
            4'd0:    k = CNT_W'(333333);
            4'd1:    k = CNT_W'(83333);
            4'd2:    k = CNT_W'(41667);
            4'd3:    k = CNT_W'(20833);
            4'd4:    k = CNT_W'(10417);
            4'd5:    k = CNT_W'(5208);
            4'd6:    k = CNT_W'(2604);
            4'd7:    k = CNT_W'(1736);
            4'd8:    k = CNT_W'(868);
            4'd9:    k = CNT_W'(434);
            4'd10:   k = CNT_W'(217);
            default: k = CNT_W'(109);
        endcase
        if (BAUD_OVERRIDE != 0) begin
            k = CNT_W'(BAUD_OVERRIDE);
        end
        return k;
    endfunction

    // Builds the frame, index 0 transmitted first. Data width, parity enable
    // and parity sense are fully encoded here, so they need no separate
    // storage once the frame is loaded.
    function automatic logic [10:0] build_frame(input logic [7:0] d,
                                                input logic       e8,
                                                input logic       par_en,
                                                input logic       odd);
        logic       p;
        logic       par;
        logic       b8;
        logic       b9;
        p   = e8 ? (^d[7:0]) : (^d[6:0]);
        par = odd ? ~p : p;
        b8  = e8 ? d[7] : (par_en ? par : 1'b1);
        b9  = (e8 & par_en) ? par : 1'b1;
        return {1'b1, b9, b8, d[6:0], 1'b0};
    endfunction

    assign accept   = (state_q == IDLE) && load;
    assign btu      = (state_q == SEND) && (bit_time_q == kmax_q);
    assign last_bit = btu && (bit_cnt_q == 4'd10);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)     state_d = SEND;
            SEND:    if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q    <= '1;
            kmax_q     <= '0;
            bit_time_q <= '0;
            bit_cnt_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= last_bit;
            if (accept) begin
                shreg_q    <= build_frame(out_port, eight, pen, ohel);
                kmax_q     <= clocks_per_bit(baud_sel) - CNT_W'(1);
                bit_time_q <= '0;
                bit_cnt_q  <= '0;
            end else if (state_q == SEND) begin
                if (btu) begin
                    // Shift in ones so the line sits at the stop level after
                    // the last bit and between frames.
                    bit_time_q <= '0;
                    shreg_q    <= {1'b1, shreg_q[10:1]};
                    bit_cnt_q  <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;
                end else begin
                    bit_time_q <= bit_time_q + CNT_W'(1);
                end
            end
        end
    end

    assign tx      = shreg_q[0];
    assign txrdy   = (state_q == IDLE);
    assign busy    = (state_q == SEND);
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_engine. Instance dut0 runs with a 4-clock bit
// period, and instance dut1 uses the baud_sel table (baud_sel=11, 109 clocks).
module tb_uart_tx_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic       ld;
    logic       sel;
    logic [7:0] out_port;
    logic [3:0] baud_sel;
    logic       eight, pen, ohel;
    logic       load0, load1;
    logic       tx0, txrdy0, tx_done0, busy0;
    logic       tx1, txrdy1, tx_done1, busy1;
    logic       tx_m, txrdy_m, tx_done_m, busy_m;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign load0     = ld & ~sel;
    assign load1     = ld & sel;
    assign tx_m      = sel ? tx1      : tx0;
    assign txrdy_m   = sel ? txrdy1   : txrdy0;
    assign tx_done_m = sel ? tx_done1 : tx_done0;
    assign busy_m    = sel ? busy1    : busy0;

    uart_tx_engine #(.BAUD_OVERRIDE(4), .CNT_W(19)) dut0 (
        .clock(clock), .reset(reset), .load(load0), .out_port(out_port),
        .baud_sel(baud_sel), .eight(eight), .pen(pen), .ohel(ohel),
        .tx(tx0), .txrdy(txrdy0), .tx_done(tx_done0), .busy(busy0)
    );

    uart_tx_engine #(.BAUD_OVERRIDE(0), .CNT_W(19)) dut1 (
        .clock(clock), .reset(reset), .load(load1), .out_port(out_port),
        .baud_sel(baud_sel), .eight(eight), .pen(pen), .ohel(ohel),
        .tx(tx1), .txrdy(txrdy1), .tx_done(tx_done1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the load is accepted on the following posedge.
    task automatic drive(input logic [7:0] d, input logic e, input logic p, input logic o);
        out_port = d;
        eight    = e;
        pen      = p;
        ohel     = o;
        ld       = 1'b1;
        @(posedge clock);
        #1;
        ld = 1'b0;
    endtask

    // Follows one frame from its start-bit cycle to the tx_done cycle.
    // ign_at >= 0 issues a stray load (with altered config) in that cycle.
    task automatic body(input logic [10:0] expb, input int k, input int ign_at);
        for (int c = 0; c < 11 * k; c++) begin
            @(negedge clock);
            chk($sformatf("tx_bit%0d_c%0d", c / k, c), tx_m, expb[c / k]);
            chk($sformatf("rdy_busy_done_c%0d", c), {txrdy_m, busy_m, tx_done_m}, 3'b010);
            if (ign_at >= 0 && c == ign_at) begin
                out_port = 8'h00;
                eight    = 1'b0;
                pen      = 1'b1;
                ohel     = 1'b1;
                ld       = 1'b1;
            end
            if (ign_at >= 0 && c == ign_at + 1) ld = 1'b0;
        end
        @(negedge clock);
        chk("frame_end", {tx_m, txrdy_m, busy_m, tx_done_m}, 4'b1101);
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk($sformatf("idle_%0d", i), {tx_m, txrdy_m, busy_m, tx_done_m}, 4'b1100);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        ld       = 1'b0;
        sel      = 1'b0;
        out_port = 8'h00;
        baud_sel = 4'd11;
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;

        repeat (3) @(negedge clock);
        chk("reset_dut0", {tx0, txrdy0, busy0, tx_done0}, 4'b1100);
        chk("reset_dut1", {tx1, txrdy1, busy1, tx_done1}, 4'b1100);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", {tx0, txrdy0, busy0, tx_done0}, 4'b1100);

        // Reset in the middle of a frame
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("started_busy", {txrdy0, busy0}, 2'b01);
        repeat (29) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_reset_mid", {tx0, txrdy0, busy0, tx_done0}, 4'b1100);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1,1
        drive(8'hA5, 1'b1, 1'b0, 1'b0);
        body(11'h74A, 4, -1);
        idle_chk(2);

        // 7E1 0x43 then 7O1 0x43
        drive(8'h43, 1'b0, 1'b1, 1'b0);
        body(11'h786, 4, -1);
        idle_chk(1);
        drive(8'h43, 1'b0, 1'b1, 1'b1);
        body(11'h686, 4, -1);
        idle_chk(1);

        // 8O1 0xFF
        drive(8'hFF, 1'b1, 1'b1, 1'b1);
        body(11'h7FE, 4, -1);
        idle_chk(1);

        // Stray load (0x00, altered config) mid-frame of 8N1 0xA5
        drive(8'hA5, 1'b1, 1'b0, 1'b0);
        body(11'h74A, 4, 10);
        idle_chk(4);

        // Table rate (baud_sel=11 -> 109 clocks), back-to-back 8N1 0xA5 then 8E1 0x3C
        sel = 1'b1;
        @(negedge clock);
        drive(8'hA5, 1'b1, 1'b0, 1'b0);
        body(11'h74A, 109, -1);
        drive(8'h3C, 1'b1, 1'b1, 1'b0);
        body(11'h478, 109, -1);
        idle_chk(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
